// File: rtl/rr_mux_arb_pkg.sv
// Shared types and defaults for the round-robin output-mux arbiter.
package rr_mux_arb_pkg;

   localparam int unsigned N_REQ_DEF = 4;
   localparam int unsigned DW_DEF    = 8;
   localparam int unsigned BURST_DEF = 4;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // Width of an index into n entries; never zero.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_mux_arb_if.sv
// Requester/downstream bundle for rr_mux_arb; the arbiter uses the slave modport.
interface rr_mux_arb_if
   import rr_mux_arb_pkg::*;
#(
   parameter int unsigned N_REQ = N_REQ_DEF,
   parameter int unsigned DW    = DW_DEF
);
   logic [N_REQ-1:0]    req_i;
   logic [N_REQ*DW-1:0] data_i;
   logic [N_REQ-1:0]    ack_o;
   logic [N_REQ-1:0]    sel_o;
   logic                valid_o;
   logic [DW-1:0]       data_o;
   logic                ready_i;

   modport master (
      output req_i, data_i, ready_i,
      input  ack_o, sel_o, valid_o, data_o
   );

   modport slave (
      input  req_i, data_i, ready_i,
      output ack_o, sel_o, valid_o, data_o
   );
endinterface

// File: rtl/rr_mux_arb_onehot_mux.sv
// AND-OR data selector driven by a one-hot (or all-zero) select.
module onehot_mux #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned DW    = 8
) (
   input  logic [N_REQ-1:0]    sel,
   input  logic [N_REQ*DW-1:0] data,
   output logic [DW-1:0]       data_c
);

   always_comb begin
      data_c = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         data_c = data_c | (data[i*DW +: DW] & {DW{sel[i]}});
      end
   end

endmodule

// File: rtl/rr_mux_arb.sv
// Round-robin arbiter feeding a registered output mux with ready/valid downstream.
// Optional burst grants compiled in with RR_MUX_ARB_BURST_EN.
module rr_mux_arb
   import rr_mux_arb_pkg::*;
#(
   parameter int unsigned N_REQ = N_REQ_DEF,
   parameter int unsigned DW    = DW_DEF,
   parameter int unsigned BURST = BURST_DEF
) (
   input logic           clk_i,
   input logic           reset_i,
   rr_mux_arb_if.slave   bus
);

   localparam int unsigned PW = idx_w(N_REQ);

   state_t           state_q, state_d;
   logic [N_REQ-1:0] sel_q, sel_d;
   logic [DW-1:0]    data_q;
   logic [DW-1:0]    mux_data;
   logic [PW-1:0]    ptr_q, ptr_d;
   logic [PW-1:0]    gnt_idx;
   logic [PW-1:0]    nxt_ptr;
   logic [PW-1:0]    scan_start;
   logic [N_REQ-1:0] excl;
   logic [N_REQ-1:0] pick;
   logic             hs;
   logic             load;
   logic             keep;

   // First eligible requester scanning upward from start with wrap.
   function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] elig,
                                                input logic [PW-1:0]    start);
      logic [N_REQ-1:0] res;
      logic             found;
      int unsigned      k;
      res   = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         k = (32'(start) + i) % N_REQ;
         if (!found && elig[PW'(k)]) begin
            res[PW'(k)] = 1'b1;
            found       = 1'b1;
         end
      end
      return res;
   endfunction

   always_comb begin
      gnt_idx = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (sel_q[i]) gnt_idx = PW'(i);
      end
      nxt_ptr = (gnt_idx == PW'(N_REQ - 1)) ? '0 : gnt_idx + PW'(1);
   end

   assign hs = (state_q == BUSY) && bus.ready_i;

   // The requester being acked still shows its accepted beat, so it is masked out.
   assign excl       = hs ? sel_q : '0;
   assign scan_start = hs ? nxt_ptr : ptr_q;
   assign pick       = rr_pick(bus.req_i & ~excl, scan_start);

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      load    = 1'b0;
      case (state_q)
         IDLE: begin
            if (|pick) begin
               state_d = BUSY;
               sel_d   = pick;
               load    = 1'b1;
            end
         end
         BUSY: begin
            if (hs) begin
               if (keep) begin
                  load = 1'b1;
               end else begin
                  ptr_d = nxt_ptr;
                  if (|pick) begin
                     sel_d = pick;
                     load  = 1'b1;
                  end else begin
                     state_d = IDLE;
                     sel_d   = '0;
                  end
               end
            end
         end
         default: begin
            state_d = IDLE;
            sel_d   = '0;
         end
      endcase
   end

   onehot_mux #(
      .N_REQ (N_REQ),
      .DW    (DW)
   ) u_mux (
      .sel    (sel_d),
      .data   (bus.data_i),
      .data_c (mux_data)
   );

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         sel_q   <= '0;
         ptr_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         if (load) data_q <= mux_data;
      end
   end

`ifdef RR_MUX_ARB_BURST_EN
   localparam int unsigned CW = $clog2(BURST + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Same requester keeps the grant while it still requests and the burst has room.
   assign keep = hs && |(bus.req_i & sel_q) && (cnt_q < CW'(BURST));

   always_comb begin
      cnt_d = cnt_q;
      if (load) cnt_d = keep ? cnt_q + CW'(1) : CW'(1);
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end
`else
   logic unused_burst;

   assign keep         = 1'b0;
   assign unused_burst = (BURST != 0);
`endif

   assign bus.ack_o   = hs ? sel_q : '0;
   assign bus.sel_o   = sel_q;
   assign bus.valid_o = (state_q == BUSY);
   assign bus.data_o  = data_q;

endmodule

// File: doc/rr_mux_arb.md
RR_MUX_ARB -- requirements
Module: rr_mux_arb

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the output mux.
REQ-002 Parameter DW, default 8, data width per requester.
REQ-003 Parameter BURST, default 4, maximum consecutive beats per grant (used only when burst is compiled in).
REQ-004 clk_i  in  1  single clock, all state on rising edge.
REQ-005 reset_i  in  1  reset, asynchronous, active-high.
REQ-006 req_i  in  N_REQ  per-requester request, held high with stable data until acked.
REQ-007 data_i  in  N_REQ*DW  packed requester data, slice k = data_i[k*DW +: DW].
REQ-008 ack_o  out  N_REQ  one-cycle pulse to requester whose beat was accepted.
REQ-009 sel_o  out  N_REQ  one-hot current grant, all-zero when idle.
REQ-010 valid_o  out  1  data_o holds an unaccepted beat.
REQ-011 data_o  out  DW  registered beat of granted requester.
REQ-012 ready_i  in  1  downstream accepts beat when valid_o && ready_i.

Function
REQ-013 FSM has two states, IDLE (valid_o=0) and BUSY (valid_o=1).
REQ-014 Arbitration is round-robin, scanning from pointer ptr upward with wrap N_REQ-1 -> 0, and the first asserted req_i wins.
REQ-015 In IDLE with any req_i high at edge N, sel_o, data_o and valid_o=1 are registered at edge N, so the beat appears one cycle after request.
REQ-016 In BUSY with !ready_i, data_o, sel_o and valid_o hold unchanged and ack_o=0.
REQ-017 In BUSY with ready_i, ack_o[granted] is asserted combinationally that cycle and ptr becomes granted+1 mod N_REQ.
REQ-018 On handshake with another eligible request pending, re-arbitration occurs in the same cycle and the next beat loads at that edge (no bubble, one beat per cycle sustained).
REQ-019 Eligibility during re-arbitration excludes the requester being acked in that cycle, because its req_i still reflects the accepted beat.
REQ-020 On handshake with no eligible request, the block enters IDLE, valid_o=0, sel_o=0.
REQ-021 sel_o is always one-hot or zero, and equals zero exactly when valid_o=0.
REQ-022 A req_i deasserted while not granted is simply not selected; deassertion of the granted req_i while in BUSY does not cancel the beat.

Reset
REQ-023 reset_i high asynchronously forces IDLE, valid_o=0, sel_o=0, data_o=0, ptr=0, burst count=0, and ack_o=0.
REQ-024 Reset mid-beat discards the pending beat without an ack, and the first grant after release scans from requester 0.

Configuration
REQ-025 Macro RR_MUX_ARB_BURST_EN compiled in: on handshake, if the granted req_i is still high and the beat count is less than BURST, the same requester keeps the grant, its next beat loads, and ptr does not advance.
REQ-026 With RR_MUX_ARB_BURST_EN compiled in, the count resets to 1 on each new grant, and on reaching BURST the grant rotates per REQ-017 to REQ-019.
REQ-027 Without RR_MUX_ARB_BURST_EN, the burst counter is absent, BURST is ignored, and grants rotate after every beat.

Structure
REQ-028 Package rr_mux_arb_pkg holds the state enum (IDLE, BUSY) and the default constants N_REQ_DEF=4, DW_DEF=8, BURST_DEF=4.
REQ-029 Sub-module onehot_mux (one-hot select, N_REQ x DW AND-OR tree) selects data_i and is instantiated once.

Verification
REQ-030 Reset release, req_i=0001, data slice0=0xA5, ready_i=1 -> next cycle valid_o=1, data_o=0xA5, sel_o=0001, ack_o=0001, then IDLE.
REQ-031 req_i=1111 held, ready_i=1, burst off -> sel_o sequence 0001,0010,0100,1000,0001 on consecutive cycles, with no bubble.
REQ-032 Grant to requester 2, ready_i=0 for 5 cycles -> data_o and sel_o=0100 stable, ack_o=0; ready_i=1 -> single ack_o=0100.
REQ-033 With RR_MUX_ARB_BURST_EN, BURST=4, req_i=0011 held -> 4 beats sel_o=0001, then 4 beats sel_o=0010.
REQ-034 reset_i pulsed while valid_o=1, sel_o=1000 -> valid_o=0 immediately, no ack; after release with req_i=1001 -> sel_o=0001 first.
REQ-035 Random req_i and ready_i for 1000 cycles -> sel_o one-hot or zero always, at most one ack_o bit per cycle, and each requester is granted within N_REQ beats of requesting (N_REQ*BURST with burst on).
